// File: rtl/xoodoo_pkg.sv
// Shared definitions for the XOODOO permutation arbiter.
// Optional feature macro used by the arbiter: XOODOO_ARB_TIMEOUT_EN.
package xoodoo_pkg;

  // Width of one XOODOO state (3 planes x 4 lanes x 32 bits).
  localparam int STATE_W = 384;

  // Largest supported number of requesters and the index width that covers it.
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  // Successor of a requester index, wrapping at the configured count.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input int             num);
    logic [IDX_W-1:0] nxt;
    if (idx == IDX_W'(num - 1)) begin
      nxt = {IDX_W{1'b0}};
    end else begin
      nxt = idx + IDX_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/xoodoo_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping modulo N. Produces a one-hot grant and the binary index.
module xoodoo_rr_pick
  import xoodoo_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  // Rotate the search start to ptr and take the first requester found.
  always_comb begin
    int cand;
    any  = 1'b0;
    gnt  = {N{1'b0}};
    idx  = {IDX_W{1'b0}};
    cand = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      cand = (cand >= N) ? (cand - N) : cand;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end else begin
        gnt = gnt;
      end
    end
  end

endmodule

// File: rtl/xoodoo_perm_arbiter.sv
// Round-robin arbiter sharing one XOODOO permutation core among NUM_REQ
// requesters. One transaction in flight: accept, launch, wait, respond.
// Optional watchdog in WAIT enabled by defining XOODOO_ARB_TIMEOUT_EN.
module xoodoo_perm_arbiter
  import xoodoo_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*STATE_W-1:0] req_state,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [STATE_W-1:0]         rsp_state,
  output logic                       rsp_error,
  output logic                       busy,
  output logic                       xoodoo_enable,
  output logic [STATE_W-1:0]         xoodoo_state_out,
  input  logic [STATE_W-1:0]         xoodoo_state_in,
  input  logic                       xoodoo_complete
);

  // Reject configurations outside the supported range at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("xoodoo_perm_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t         arb_q, arb_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [STATE_W-1:0] state_q, state_d;

  logic               pick_any_s;
  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic [STATE_W-1:0] sel_state_s;

  xoodoo_rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any_s),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s)
  );

  // Mux the winning requester's state slice.
  always_comb begin
    sel_state_s = {STATE_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx_s == IDX_W'(i)) begin
        sel_state_s = req_state[i*STATE_W +: STATE_W];
      end else begin
        sel_state_s = sel_state_s;
      end
    end
  end

`ifdef XOODOO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             err_q, err_d;
`endif

  // Next-state logic: arbitration, launch, completion capture, pointer advance.
  always_comb begin
    arb_d    = arb_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    state_d  = state_q;
`ifdef XOODOO_ARB_TIMEOUT_EN
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q;
`endif
    case (arb_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = sel_state_s;
          owner_d = pick_idx_s;
          arb_d   = LAUNCH;
        end else begin
          arb_d = IDLE;
        end
      end
      LAUNCH: begin
        arb_d = WAIT;
`ifdef XOODOO_ARB_TIMEOUT_EN
        wd_cnt_d = {CNT_W{1'b0}};
        err_d    = 1'b0;
`endif
      end
      WAIT: begin
        if (xoodoo_complete) begin
          // Completion wins even when it coincides with the watchdog limit.
          state_d = xoodoo_state_in;
          arb_d   = RESPOND;
`ifdef XOODOO_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This is the TIMEOUT_CYCLES-th WAIT cycle without completion.
          state_d = {STATE_W{1'b0}};
          err_d   = 1'b1;
          arb_d   = RESPOND;
        end else begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
          arb_d    = WAIT;
        end
`else
        end else begin
          arb_d = WAIT;
        end
`endif
      end
      RESPOND: begin
        rr_ptr_d = next_idx(owner_q, NUM_REQ);
        arb_d    = IDLE;
      end
      default: begin
        arb_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset; an in-flight transaction is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arb_q    <= IDLE;
      rr_ptr_q <= {IDX_W{1'b0}};
      owner_q  <= {IDX_W{1'b0}};
      state_q  <= {STATE_W{1'b0}};
`ifdef XOODOO_ARB_TIMEOUT_EN
      wd_cnt_q <= {CNT_W{1'b0}};
      err_q    <= 1'b0;
`endif
    end else begin
      arb_q    <= arb_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      state_q  <= state_d;
`ifdef XOODOO_ARB_TIMEOUT_EN
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Output decode: handshake strobes from FSM state, data straight from state_q.
  always_comb begin
    busy             = (arb_q != IDLE);
    xoodoo_enable    = (arb_q == LAUNCH);
    xoodoo_state_out = state_q;
    rsp_state        = state_q;
    if (arb_q == IDLE && !reset) begin
      req_ready = pick_gnt_s;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (arb_q == RESPOND) && (owner_q == IDX_W'(i));
    end
`ifdef XOODOO_ARB_TIMEOUT_EN
    rsp_error = err_q && (arb_q == RESPOND);
`else
    rsp_error = 1'b0;
`endif
  end

endmodule

// File: doc/xoodoo_perm_arbiter.md
# xoodoo_perm_arbiter

Round-robin scheduler that shares a single XOODOO permutation core among `NUM_REQ` requesters, typically XOODYAK hash/AEAD engine instances. It accepts one 384-bit state per transaction, launches the core with a one-cycle `xoodoo_enable` pulse, waits for `xoodoo_complete`, and returns the permuted state to the owning requester. It sits between the XOODYAK engines and the XOODOO core and is the only driver of the core's `start` and `state_in`.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 64: watchdog limit in WAIT. Used only with `XOODOO_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_state`  in  NUM_REQ*384  request states; requester i at bits [i*384 +: 384].
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle result strobe.
- `rsp_state`  out  384  permuted state, valid while any `rsp_valid` bit is high.
- `rsp_error`  out  1  timeout flag, qualified by `rsp_valid`.
- `busy`  out  1  high in any state other than IDLE.
- `xoodoo_enable`  out  1  one-cycle start pulse to the core.
- `xoodoo_state_out`  out  384  state presented to the core's `state_in`.
- `xoodoo_state_in`  in  384  core `state_out`.
- `xoodoo_complete`  in  1  core `done_permutations`.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESPOND.
- **IDLE**
  - If any `req_valid` bit is set, select the first set bit searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Assert `req_ready[sel]` combinationally in the same cycle.
  - On that edge, latch `req_state[sel]` into `state_q`, latch `owner <= sel`, and go to LAUNCH.
- **LAUNCH**
  - `xoodoo_enable = 1` for exactly one cycle, then go to WAIT.
- **WAIT**
  - When `xoodoo_complete = 1`, latch `xoodoo_state_in` into `state_q` and go to RESPOND.
  - `xoodoo_complete` is ignored in every other state.
- **RESPOND**
  - `rsp_valid[owner] = 1` and `rsp_state = state_q` for one cycle.
  - Then `rr_ptr <= (owner+1) mod NUM_REQ` and go to IDLE.
- `xoodoo_state_out = state_q` at all times; it is stable from LAUNCH through WAIT.
- Requester handshake:
  - A requester holds `req_valid` and `req_state` until it sees `req_ready`.
  - Deasserting `req_valid` before the grant is legal, because arbitration is re-evaluated every IDLE cycle.
- Requests arriving while `busy` wait; no queueing beyond the level-held `req_valid`.
- One transaction in flight at a time.
- Reset values:
  - FSM = IDLE, `rr_ptr = 0`, `owner = 0`, `state_q = 0`.
  - All outputs are 0: `req_ready`, `rsp_valid`, `rsp_error`, `busy`, `xoodoo_enable`, and `xoodoo_state_out`.
- Reset mid-transaction aborts it with no response issued. The core is reset by the shared system reset at the same time.

## Timing
- Accept cycle T (IDLE, `req_ready` high), then `xoodoo_enable` at T+1.
- The core raises `xoodoo_complete` at cycle C ≥ T+2.
- `rsp_valid` at C+1; IDLE at C+2.
- Minimum gap between the last response and the next accept: 1 cycle (the IDLE cycle at C+2 can accept).
- Latency from accept to response is core latency + 2 cycles.
- `req_ready` is combinational from `req_valid` and `rr_ptr`.
- All other outputs are registered or decoded from FSM state only.

## Configuration
- `XOODOO_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` without `xoodoo_complete`, go to RESPOND with `rsp_error = 1` and `state_q` cleared to 0.
  - If `xoodoo_complete` and the limit coincide, completion wins and `rsp_error = 0`.
- Not defined:
  - No counter; WAIT persists until `xoodoo_complete`.
  - `rsp_error` is tied to 0.

## Structure
- Shared package `xoodoo_pkg`:
  - `STATE_W = 384`.
  - FSM state enum `arb_state_t` (IDLE/LAUNCH/WAIT/RESPOND).
  - `MAX_REQ = 8`.
- One sub-module, `xoodoo_rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector and `ptr`.
  - Outputs: `any`, one-hot `gnt`, and binary `idx`.

## Test plan
Use a behavioural core model with a fixed 13-cycle latency.
- Single request: requester 0 sends state 0x00..01.
  - `req_ready[0]` in the same cycle and `xoodoo_enable` exactly once.
  - `rsp_valid[0]` 15 cycles after accept, with `rsp_state` equal to the model's output.
- Simultaneous `req_valid = 2'b11` held continuously, with `NUM_REQ = 2`: grants alternate 0,1,0,1 and no requester is served twice in a row.
- `NUM_REQ = 4`, `rr_ptr = 3`, requests on bits 1 and 3: 3 is served, then 1 (wrap).
- Assert `reset` during WAIT:
  - No `rsp_valid`, and all outputs are 0 immediately (asynchronous).
  - After release, a new request completes normally with `rr_ptr = 0`.
- With `XOODOO_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES = 64`, a core model that never completes: `rsp_valid[owner]` with `rsp_error = 1` and `rsp_state = 0` at 64 WAIT cycles + 1.
- Without the macro, the same never-completing stimulus: `busy` stays 1 for 1000 cycles, `rsp_error` never rises, and a spurious `xoodoo_complete` in IDLE is ignored.
